// File: rtl/tug_of_war_referee.sv
// tug_of_war_referee: round/match controller for the tug-of-war game.
// Synchronizes and edge-detects both player buttons, moves a shared rope
// position, detects round wins, keeps best-of-N scores and drives the LED bar.
// Optional feature: define TOW_FOUL_EN to penalize presses made in READY
// (false start); otherwise READY ignores presses and foul is tied low.
module tug_of_war_referee #(
    parameter int LED_W      = 15,
    parameter int WIN_ROUNDS = 2,
    parameter int LOCK_CYC   = 4,
    parameter int HOLD_CYC   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             btn_l,
    input  logic             btn_r,
    output logic [LED_W-1:0] led,
    output logic [1:0]       score_l,
    output logic [1:0]       score_r,
    output logic [2:0]       state,
    output logic             match_over,
    output logic             winner,
    output logic             foul
);

    localparam int C  = (LED_W - 1) / 2;
    localparam int PW = $clog2(LED_W);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    localparam logic [PW-1:0]    POS_C   = PW'(C);
    localparam logic [PW-1:0]    POS_MAX = PW'(LED_W - 1);
    localparam logic [PW-1:0]    POS_ONE = PW'(1);
    localparam logic [1:0]       WIN_S   = 2'(WIN_ROUNDS);
    localparam logic [LW-1:0]    LOCK_V  = LW'(LOCK_CYC);
    localparam logic [HW-1:0]    HOLD_V  = HW'(HOLD_CYC - 1);
    localparam logic [LED_W-1:0] ALL_ON  = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] MASK_L  = ALL_ON << (C + 1);
    localparam logic [LED_W-1:0] MASK_R  = ALL_ON >> (C + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        PLAY      = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4
    } state_t;

    state_t st_q, st_d;

    logic btn_l_p0, btn_l_p1, btn_l_p2;
    logic btn_r_p0, btn_r_p1, btn_r_p2;
    logic edge_l, edge_r, acc_l, acc_r;

    logic [PW-1:0]    pos_q, pos_d;
    logic [LW-1:0]    lock_l_q, lock_l_d, lock_r_q, lock_r_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [1:0]       score_l_d, score_r_d;
    logic             winner_d;
    logic [LED_W-1:0] led_d;

    // Scores stop at the match target instead of wrapping.
    function automatic logic [1:0] sat_inc(input logic [1:0] s);
        return (s >= WIN_S) ? s : s + 2'd1;
    endfunction

    // LED pattern for a given state, rope position and winner.
    function automatic logic [LED_W-1:0] led_map(input state_t s,
                                                 input logic [PW-1:0] p,
                                                 input logic w);
        logic [LED_W-1:0] v;
        case (s)
            READY, PLAY, ROUND_END: v = LED_W'(1) << p;
            MATCH_END:              v = w ? MASK_L : MASK_R;
            default:                v = '0;
        endcase
        return v;
    endfunction

    assign state  = st_q;
    assign edge_l = btn_l_p1 & ~btn_l_p2;
    assign edge_r = btn_r_p1 & ~btn_r_p2;
    assign acc_l  = edge_l && (lock_l_q == '0);
    assign acc_r  = edge_r && (lock_r_q == '0);

`ifdef TOW_FOUL_EN
    logic foul_d;
`else
    assign foul = 1'b0;
`endif

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_l_p0 <= 1'b0;
            btn_l_p1 <= 1'b0;
            btn_l_p2 <= 1'b0;
            btn_r_p0 <= 1'b0;
            btn_r_p1 <= 1'b0;
            btn_r_p2 <= 1'b0;
        end else begin
            btn_l_p0 <= btn_l;
            btn_l_p1 <= btn_l_p0;
            btn_l_p2 <= btn_l_p1;
            btn_r_p0 <= btn_r;
            btn_r_p1 <= btn_r_p0;
            btn_r_p2 <= btn_r_p1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= IDLE;
        else        st_q <= st_d;
    end

    // Next-state, rope movement, scoring and LED decode.
    always_comb begin
        st_d      = st_q;
        pos_d     = pos_q;
        score_l_d = score_l;
        score_r_d = score_r;
        winner_d  = winner;
        hold_d    = hold_q;
        lock_l_d  = (lock_l_q != '0) ? lock_l_q - 1'b1 : '0;
        lock_r_d  = (lock_r_q != '0) ? lock_r_q - 1'b1 : '0;
`ifdef TOW_FOUL_EN
        foul_d    = 1'b0;
`endif
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_d  = READY;
                    pos_d = POS_C;
                end
            end
            READY: begin
                pos_d = POS_C;
`ifdef TOW_FOUL_EN
                // A lone press before the go signal hands the round to the opponent.
                if (acc_l != acc_r) begin
                    if (acc_l) begin
                        lock_l_d  = LOCK_V;
                        score_r_d = sat_inc(score_r);
                        winner_d  = 1'b0;
                    end else begin
                        lock_r_d  = LOCK_V;
                        score_l_d = sat_inc(score_l);
                        winner_d  = 1'b1;
                    end
                    foul_d = 1'b1;
                    st_d   = ROUND_END;
                    hold_d = HOLD_V;
                end else if (start) begin
                    st_d = PLAY;
                end
`else
                if (start) st_d = PLAY;
`endif
            end
            PLAY: begin
                // Simultaneous accepted presses cancel and leave both lockouts idle.
                if (acc_l && !acc_r) begin
                    lock_l_d = LOCK_V;
                    pos_d    = pos_q + POS_ONE;
                    if (pos_d == POS_MAX) begin
                        score_l_d = sat_inc(score_l);
                        winner_d  = 1'b1;
                        st_d      = ROUND_END;
                        hold_d    = HOLD_V;
                    end
                end else if (acc_r && !acc_l) begin
                    lock_r_d = LOCK_V;
                    pos_d    = pos_q - POS_ONE;
                    if (pos_d == '0) begin
                        score_r_d = sat_inc(score_r);
                        winner_d  = 1'b0;
                        st_d      = ROUND_END;
                        hold_d    = HOLD_V;
                    end
                end
            end
            ROUND_END: begin
                if (hold_q == '0) begin
                    if ((winner ? score_l : score_r) == WIN_S) begin
                        st_d = MATCH_END;
                    end else begin
                        st_d  = READY;
                        pos_d = POS_C;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            MATCH_END: begin
                if (start) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    st_d      = READY;
                    pos_d     = POS_C;
                end
            end
            default: st_d = IDLE;
        endcase
        led_d = led_map(st_d, pos_d, winner_d);
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= POS_C;
            lock_l_q   <= '0;
            lock_r_q   <= '0;
            hold_q     <= '0;
            score_l    <= '0;
            score_r    <= '0;
            winner     <= 1'b0;
            match_over <= 1'b0;
            led        <= '0;
        end else begin
            pos_q      <= pos_d;
            lock_l_q   <= lock_l_d;
            lock_r_q   <= lock_r_d;
            hold_q     <= hold_d;
            score_l    <= score_l_d;
            score_r    <= score_r_d;
            winner     <= winner_d;
            match_over <= (st_d == MATCH_END);
            led        <= led_d;
        end
    end

`ifdef TOW_FOUL_EN
    // One-cycle false-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) foul <= 1'b0;
        else        foul <= foul_d;
    end
`endif

endmodule

// File: tb/tb_tug_of_war_referee.sv
// Directed testbench for tug_of_war_referee (default parameters).
module tb_tug_of_war_referee;

    logic        clk = 1'b0;
    logic        rst_n, start, btn_l, btn_r;
    logic [14:0] led;
    logic [1:0]  score_l, score_r;
    logic [2:0]  state;
    logic        match_over, winner, foul;

    int tests = 0;
    int fails = 0;
    int exp_pos;

    tug_of_war_referee dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .led        (led),
        .score_l    (score_l),
        .score_r    (score_r),
        .state      (state),
        .match_over (match_over),
        .winner     (winner),
        .foul       (foul)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press; returns just after the edge where the rope moves.
    task automatic press_l();
        btn_l = 1'b1; cyc(1); btn_l = 1'b0; cyc(2);
    endtask

    task automatic press_r();
        btn_r = 1'b1; cyc(1); btn_r = 1'b0; cyc(2);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        cyc(2);
        chk("rst_state", state, 0);
        chk("rst_led", led, 0);
        chk("rst_scores", {score_l, score_r}, 0);
        chk("rst_flags", {match_over, winner, foul}, 0);

        rst_n = 1'b1;
        cyc(20);
        chk("idle_state", state, 0);
        chk("idle_led", led, 0);
        chk("idle_scores", {score_l, score_r}, 0);

        pulse_start();
        chk("ready_state", state, 1);
        chk("ready_led", led, 15'h0080);
        pulse_start();
        chk("play_state", state, 2);
        chk("play_led", led, 15'h0080);

        btn_l = 1'b1; btn_r = 1'b1; cyc(1); btn_l = 1'b0; btn_r = 1'b0; cyc(2);
        chk("simul_led", led, 15'h0080);
        cyc(6);

        btn_l = 1'b1; cyc(1); btn_l = 1'b0; cyc(1); btn_l = 1'b1; cyc(1); btn_l = 1'b0;
        cyc(8);
        chk("lockout_led", led, 15'h0100);

        exp_pos = 8;
        for (int i = 0; i < 6; i++) begin
            press_l();
            exp_pos++;
            chk("r1_led", led, 32'd1 << exp_pos);
            if (i < 5) cyc(7);
        end
        chk("r1_state", state, 3);
        chk("r1_led_end", led, 15'h4000);
        chk("r1_score_l", score_l, 1);
        chk("r1_score_r", score_r, 0);
        chk("r1_winner", winner, 1);
        chk("r1_match_over", match_over, 0);
        cyc(7);
        chk("r1_hold7", state, 3);
        cyc(1);
        chk("r1_hold8_state", state, 1);
        chk("r1_hold8_led", led, 15'h0080);

        pulse_start();
        press_r();
        chk("r2_right_led", led, 15'h0040);
        cyc(2);
        exp_pos = 6;
        for (int i = 0; i < 8; i++) begin
            press_l();
            exp_pos++;
            chk("r2_led", led, 32'd1 << exp_pos);
            if (i < 7) cyc(2);
        end
        chk("r2_state", state, 3);
        chk("r2_score_l", score_l, 2);
        start = 1'b1;
        cyc(8);
        start = 1'b0;
        chk("match_state", state, 4);
        chk("match_over", match_over, 1);
        chk("match_winner", winner, 1);
        chk("match_led", led, 15'h7F00);
        chk("match_score_l", score_l, 2);

        pulse_start();
        chk("restart_state", state, 1);
        chk("restart_scores", {score_l, score_r}, 0);
        chk("restart_match_over", match_over, 0);
        chk("restart_led", led, 15'h0080);

        press_l();
`ifdef TOW_FOUL_EN
        chk("foul_pulse", foul, 1);
        chk("foul_state", state, 3);
        chk("foul_score_r", score_r, 1);
        chk("foul_winner", winner, 0);
        chk("foul_led", led, 15'h0080);
        cyc(1);
        chk("foul_once", foul, 0);
        cyc(7);
        chk("foul_back_ready", state, 1);
`else
        chk("nofoul_state", state, 1);
        chk("nofoul_foul", foul, 0);
        cyc(1);
        chk("nofoul_foul2", foul, 0);
        chk("nofoul_led", led, 15'h0080);

        pulse_start();
        exp_pos = 7;
        for (int i = 0; i < 7; i++) begin
            press_r();
            exp_pos--;
            chk("rr_led", led, 32'd1 << exp_pos);
            if (i < 6) cyc(2);
        end
        chk("rr_state", state, 3);
        chk("rr_score_r", score_r, 1);
        chk("rr_winner", winner, 0);
        cyc(8);
        chk("rr_back_ready", state, 1);
`endif

        pulse_start();
        chk("mid_play", state, 2);
        for (int i = 0; i < 3; i++) begin
            press_l();
            cyc(2);
        end
        chk("mid_led", led, 15'h0400);
        chk("mid_score_r", score_r, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_led", led, 0);
        chk("arst_scores", {score_l, score_r}, 0);
        chk("arst_flags", {match_over, winner, foul}, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tug_of_war_referee.md
# tug_of_war_referee

Match controller for the tug-of-war game: it sequences rounds, arbitrates the two players' button presses onto a single rope-position counter, and detects round wins. It also keeps per-player scores for a best-of-N match. The controller sits between the raw start/player buttons and the LED bar, and owns the game's state machine.

## Interface
- `LED_W`, 15, LED bar width (odd, ≥5); center index `C = (LED_W-1)/2`.
- `WIN_ROUNDS`, 2, round wins needed to take the match (1..3).
- `LOCK_CYC`, 4, per-player lockout cycles after an accepted press.
- `HOLD_CYC`, 8, cycles spent in ROUND_END.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled directly, no synchronizer.
- `btn_l`  in  1  left player button, asynchronous.
- `btn_r`  in  1  right player button, asynchronous.
- `led`  out  LED_W  LED bar drive.
- `score_l`, `score_r`  out  2  round wins per player.
- `state`  out  3  current FSM state code.
- `match_over`  out  1  high in MATCH_END.
- `winner`  out  1  1 = left, 0 = right; valid in ROUND_END and MATCH_END.
- `foul`  out  1  one-cycle pulse on a false start (see Configuration).

## Operation
- **Button path:** `btn_l` and `btn_r` each go through a 2-flop synchronizer, then a rising-edge detector. Levels and held buttons never move the rope.
- **States and codes:** IDLE=0, READY=1, PLAY=2, ROUND_END=3, MATCH_END=4.
- **IDLE:** `led` = 0. `start` moves to READY.
- **READY:** `pos` = C. `start` moves to PLAY.
- **PLAY:**
  - Accepted left edge: `pos+1`. Accepted right edge: `pos-1`.
  - Both edges in the same cycle: no move, and neither lockout is loaded.
  - An edge is accepted only when that player's lockout counter is 0. Acceptance loads the counter with LOCK_CYC; it then decrements to 0.
- **Round win:** next `pos` == LED_W-1 means left wins; next `pos` == 0 means right wins. On that same edge:
  - `pos` updates;
  - the winner's score increments;
  - `winner` is set;
  - the FSM enters ROUND_END and loads the hold counter.
- **ROUND_END:** after HOLD_CYC cycles, go to MATCH_END if the winner's score == WIN_ROUNDS. Otherwise go to READY with `pos` = C.
- **MATCH_END:** `start` clears both scores and moves to READY.
- **LED map:**
  - IDLE: all 0.
  - READY, PLAY, ROUND_END: one-hot at `pos`.
  - MATCH_END, left winner: bits LED_W-1..C+1 set.
  - MATCH_END, right winner: bits C-1..0 set.
- **Scores:** saturate at WIN_ROUNDS and never wrap.
- **`start` in PLAY or ROUND_END:** ignored.

## Timing
- **Reset values:**
  - state IDLE, `pos` = C;
  - `led` = 0, scores = 0;
  - `match_over` = 0, `winner` = 0, `foul` = 0;
  - lockout, hold and synchronizer flops = 0.
- **Reset mid-round:** returns immediately to these values; no score is retained.
- **Press latency:** let edge n be the first rising `clk` edge that samples the button high. `pos` and `led` update at edge n+2.
- **Minimum accepted press spacing:** LOCK_CYC+1 cycles per player.
- **State change on `start`:** at the first edge that samples `start` = 1.
- **ROUND_END duration:** exactly HOLD_CYC cycles. The next state is entered at edge HOLD_CYC after entry.
- **Outputs:** all registered except `state`, which is the state register itself.

## Configuration
- **Macro:** `TOW_FOUL_EN`.
- **Defined:**
  - A single accepted button edge in READY is a false start. The opponent's score increments, `winner` = opponent, `foul` pulses for one cycle, and the FSM goes to ROUND_END with `pos` = C.
  - Simultaneous edges from both players in READY: no score, no `foul`, stay in READY.
- **Undefined:** edges in READY are ignored, and `foul` is tied to 0.

## Test plan
- **Reset and idle:** reset, then idle for 20 cycles -> `led` = 0, `state` = 0, scores 0. Assert `start` -> `state` = 1, `led` = 15'h0080.
- **Left round win:** READY, `start`, then 7 left presses spaced 10 cycles -> `pos` reaches 14, `led` = 15'h4000, `score_l` = 1, `state` = 3. Exactly 8 cycles later, `state` = 1 and `led` = 15'h0080.
- **Simultaneous and lockout:** `btn_l` and `btn_r` rise in the same cycle -> `led` unchanged at 15'h0080. Two left presses 2 cycles apart -> only one move, `led` = 15'h0100.
- **Match end:** left wins two rounds -> `state` = 4, `match_over` = 1, `winner` = 1, `led` = 15'h7F00. Then `start` -> scores 0, `state` = 1.
- **False start (`TOW_FOUL_EN` defined):** left press in READY -> `foul` pulses once, `score_r` = 1, `state` = 3, `led` = 15'h0080. Without the macro: `state` stays 1 and `foul` stays 0.
- **Reset mid-round:** assert `rst_n` low with `pos` = 10 and `score_r` = 1 -> all outputs return to reset values in the same cycle, with no clock needed.
